// File: rtl/bp_fe_queue_sender_pkg.sv
// Shared FE-side types: processor config, FE->BE queue message layout and sender FSM states.
package bp_fe_queue_sender_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int unsigned vaddr_width_gp               = 39;
  localparam int unsigned branch_metadata_fwd_width_gp = 32;
  localparam int unsigned instr_width_gp               = 32;
  localparam int unsigned exception_code_width_gp      = 2;

  function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

  function automatic int unsigned bp_branch_metadata_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return branch_metadata_fwd_width_gp;
      default:          return branch_metadata_fwd_width_gp;
    endcase
  endfunction

  typedef enum logic [exception_code_width_gp-1:0] {
    e_instr_page_fault   = 2'd0,
    e_instr_access_fault = 2'd1,
    e_itlb_miss          = 2'd2,
    e_icache_miss        = 2'd3
  } bp_fe_exception_code_e;

  typedef enum logic {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_msg_type_e;

  typedef enum logic {
    e_run   = 1'b0,
    e_stall = 1'b1
  } bp_fe_queue_sender_state_e;

  typedef struct packed {
    logic [vaddr_width_gp-1:0]               pc;
    logic [instr_width_gp-1:0]               instr;
    logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
  } bp_fe_fetch_s;

  localparam int unsigned fe_fetch_width_gp = $bits(bp_fe_fetch_s);

  // Exception view is padded in the LSBs so both union members share one width.
  typedef struct packed {
    logic [vaddr_width_gp-1:0]                                           vaddr;
    bp_fe_exception_code_e                                               exception_code;
    logic [fe_fetch_width_gp-vaddr_width_gp-exception_code_width_gp-1:0] padding;
  } bp_fe_exception_s;

  typedef union packed {
    bp_fe_fetch_s     fetch;
    bp_fe_exception_s exception;
  } bp_fe_msg_u;

  typedef struct packed {
    bp_fe_msg_type_e msg_type;
    bp_fe_msg_u      msg;
  } bp_fe_queue_s;

  localparam int unsigned fe_queue_width_gp = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bp_fe_queue_sender_if.sv
// FE->BE issue queue handshake: head message, valid from the sender, ready from the BE.
interface bp_fe_queue_sender_if;
  import bp_fe_queue_sender_pkg::*;

  bp_fe_queue_s fe_queue;
  logic         fe_queue_v;
  logic         fe_queue_ready;

  modport master (output fe_queue, output fe_queue_v, input  fe_queue_ready);
  modport slave  (input  fe_queue, input  fe_queue_v, output fe_queue_ready);

endinterface

// File: rtl/bp_fe_queue_buffer.sv
// Circular message buffer with synchronous clear; els_p must be a power of two so pointers wrap freely.
module bp_fe_queue_buffer #(
  parameter int unsigned els_p   = 2,
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_v,
  input  logic               deq_v,
  input  logic               clr_v,
  input  logic [width_p-1:0] data_in,
  output logic [width_p-1:0] data_out,
  output logic               full,
  output logic               empty
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [ptr_width_lp:0]   count_t;

  ptr_t               rptr_q, wptr_q;
  count_t             count_q;
  logic [width_p-1:0] mem_q [els_p];
  logic               enq_ok, deq_ok;

  assign full     = (count_q == count_t'(els_p));
  assign empty    = (count_q == '0);
  assign enq_ok   = enq_v & ~full & ~clr_v;
  assign deq_ok   = deq_v & ~empty & ~clr_v;
  assign data_out = mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (clr_v) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_ok) wptr_q <= wptr_q + ptr_t'(1);
      if (deq_ok) rptr_q <= rptr_q + ptr_t'(1);
      if (enq_ok & ~deq_ok)      count_q <= count_q + count_t'(1);
      else if (deq_ok & ~enq_ok) count_q <= count_q - count_t'(1);
    end
  end

  // Storage carries no reset; contents are only observed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (enq_ok) mem_q[wptr_q] <= data_in;
  end

endmodule

// File: rtl/bp_fe_queue_sender.sv
// Packs FE fetch results/exceptions into queue messages and stalls fetch after an exception until flush.
module bp_fe_queue_sender
  import bp_fe_queue_sender_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_default_cfg,
  parameter int unsigned els_p       = 2,
  localparam int unsigned vaddr_width_p               = bp_vaddr_width(bp_params_p),
  localparam int unsigned branch_metadata_fwd_width_p = bp_branch_metadata_width(bp_params_p),
  localparam int unsigned fe_queue_width_lp           = $bits(bp_fe_queue_s)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic                                   fetch_v_i,
  output logic                                   fetch_ready_o,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [31:0]                            fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_branch_metadata_i,
  input  logic                                   fetch_exception_v_i,
  input  bp_fe_exception_code_e                  fetch_exception_code_i,

  input  logic                                   flush_i,

  bp_fe_queue_sender_if.master                   fe_queue_if
);

  bp_fe_queue_sender_state_e  state_q;
  bp_fe_queue_s               msg;
  logic [fe_queue_width_lp-1:0] head;
  logic                       full, empty, accept, dequeue;

  assign fetch_ready_o          = (state_q == e_run) & ~full & ~flush_i & ~reset_i;
  assign accept                 = fetch_v_i & fetch_ready_o;
  assign fe_queue_if.fe_queue_v = ~empty & ~flush_i;
  assign dequeue                = fe_queue_if.fe_queue_v & fe_queue_if.fe_queue_ready;
  assign fe_queue_if.fe_queue   = bp_fe_queue_s'(head);

  always_comb begin
    msg = '0;
    if (fetch_exception_v_i) begin
      msg.msg_type                     = e_fe_exception;
      msg.msg.exception.vaddr          = fetch_pc_i;
      msg.msg.exception.exception_code = fetch_exception_code_i;
    end else begin
      msg.msg_type                      = e_fe_fetch;
      msg.msg.fetch.pc                  = fetch_pc_i;
      msg.msg.fetch.instr               = fetch_instr_i;
      msg.msg.fetch.branch_metadata_fwd = fetch_branch_metadata_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_run;
    end else begin
      case (state_q)
        e_run:   if (accept & fetch_exception_v_i) state_q <= e_stall;
        e_stall: if (flush_i) state_q <= e_run;
        default: state_q <= e_run;
      endcase
    end
  end

  // flush doubles as the buffer clear; accept/dequeue are already masked by it.
  bp_fe_queue_buffer #(
    .els_p   (els_p),
    .width_p (fe_queue_width_lp)
  ) buffer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enq_v    (accept),
    .deq_v    (dequeue),
    .clr_v    (flush_i),
    .data_in  (msg),
    .data_out (head),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_bp_fe_queue_sender.sv
// Directed scenarios plus a randomized run against a queue-based reference model of the sender.
module tb_bp_fe_queue_sender;
  import bp_fe_queue_sender_pkg::*;

  localparam int unsigned ELS = 2;
  localparam int unsigned VW  = vaddr_width_gp;
  localparam int unsigned MW  = branch_metadata_fwd_width_gp;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic                  fetch_v_i;
  logic                  fetch_ready_o;
  logic [VW-1:0]         fetch_pc_i;
  logic [31:0]           fetch_instr_i;
  logic [MW-1:0]         fetch_branch_metadata_i;
  logic                  fetch_exception_v_i;
  bp_fe_exception_code_e fetch_exception_code_i;
  logic                  flush_i;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bp_fe_queue_sender_if qif();

  bp_fe_queue_sender #(
    .bp_params_p (e_bp_default_cfg),
    .els_p       (ELS)
  ) dut (
    .clk_i                   (clk),
    .reset_i                 (reset_i),
    .fetch_v_i               (fetch_v_i),
    .fetch_ready_o           (fetch_ready_o),
    .fetch_pc_i              (fetch_pc_i),
    .fetch_instr_i           (fetch_instr_i),
    .fetch_branch_metadata_i (fetch_branch_metadata_i),
    .fetch_exception_v_i     (fetch_exception_v_i),
    .fetch_exception_code_i  (fetch_exception_code_i),
    .flush_i                 (flush_i),
    .fe_queue_if             (qif)
  );

  always #5 clk = ~clk;

  function automatic bp_fe_queue_s mk_fetch(input logic [VW-1:0] pc, input logic [31:0] instr,
                                            input logic [MW-1:0] md);
    bp_fe_queue_s m;
    m = '0;
    m.msg_type                      = e_fe_fetch;
    m.msg.fetch.pc                  = pc;
    m.msg.fetch.instr               = instr;
    m.msg.fetch.branch_metadata_fwd = md;
    return m;
  endfunction

  function automatic bp_fe_queue_s mk_exc(input logic [VW-1:0] pc, input bp_fe_exception_code_e code);
    bp_fe_queue_s m;
    m = '0;
    m.msg_type                     = e_fe_exception;
    m.msg.exception.vaddr          = pc;
    m.msg.exception.exception_code = code;
    return m;
  endfunction

  task automatic clk_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_v_i           = 1'b0;
    fetch_exception_v_i = 1'b0;
  endtask

  task automatic drive_fetch(input logic [VW-1:0] pc, input logic [31:0] instr, input logic [MW-1:0] md);
    fetch_v_i               = 1'b1;
    fetch_exception_v_i     = 1'b0;
    fetch_pc_i              = pc;
    fetch_instr_i           = instr;
    fetch_branch_metadata_i = md;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    flush_i = 1'b0;
    qif.fe_queue_ready = 1'b1;
    fetch_pc_i = '0;
    fetch_instr_i = '0;
    fetch_branch_metadata_i = '0;
    fetch_exception_code_i = e_instr_page_fault;
    idle();
    repeat (2) clk_wait();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", qif.fe_queue_v); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", fetch_ready_o); end
    clk_wait();
    reset_i = 1'b0;
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", qif.fe_queue_v); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", fetch_ready_o); end
    clk_wait();
  endtask

  task automatic test_back_to_back();
    bp_fe_queue_s exp [3];
    logic [31:0]  instr;
    logic [MW-1:0] md;
    qif.fe_queue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        instr = $urandom();
        md    = $urandom();
        exp[i] = mk_fetch(VW'(64'h8000_0000 + 64'(4 * i)), instr, md);
        drive_fetch(VW'(64'h8000_0000 + 64'(4 * i)), instr, md);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 3) begin
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, fetch_ready_o); end
      end
      if (i == 0) begin
        checks++; if (qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass: got %b want 0", qif.fe_queue_v); end
      end else begin
        checks++; if (qif.fe_queue_v !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, qif.fe_queue_v); end
        checks++; if (qif.fe_queue !== exp[i-1]) begin errors++; $display("FAIL b2b_msg[%0d]: got %h want %h", i - 1, qif.fe_queue, exp[i-1]); end
      end
      clk_wait();
    end
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", qif.fe_queue_v); end
    clk_wait();
  endtask

  task automatic test_backpressure();
    bp_fe_queue_s exp [3];
    for (int i = 0; i < 3; i++) exp[i] = mk_fetch(VW'(64'h8000_0000 + 64'(4 * i)), 32'h1000 + 32'(i), MW'(i + 7));
    qif.fe_queue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_fetch(VW'(64'h8000_0000 + 64'(4 * i)), 32'h1000 + 32'(i), MW'(i + 7));
      @(negedge clk);
      checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_fill[%0d]: got %b want 1", i, fetch_ready_o); end
      clk_wait();
    end
    drive_fetch(VW'(64'h8000_0008), 32'h1002, MW'(9));
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", fetch_ready_o); end
    checks++; if (qif.fe_queue !== exp[0]) begin errors++; $display("FAIL bp_head_full: got %h want %h", qif.fe_queue, exp[0]); end
    clk_wait();
    qif.fe_queue_ready = 1'b1;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_still_full: got %b want 0", fetch_ready_o); end
    checks++; if (qif.fe_queue_v !== 1'b1 || qif.fe_queue !== exp[0]) begin errors++; $display("FAIL bp_drain0: got v=%b %h want v=1 %h", qif.fe_queue_v, qif.fe_queue, exp[0]); end
    clk_wait();
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", fetch_ready_o); end
    checks++; if (qif.fe_queue_v !== 1'b1 || qif.fe_queue !== exp[1]) begin errors++; $display("FAIL bp_drain1: got v=%b %h want v=1 %h", qif.fe_queue_v, qif.fe_queue, exp[1]); end
    clk_wait();
    idle();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b1 || qif.fe_queue !== exp[2]) begin errors++; $display("FAIL bp_third: got v=%b %h want v=1 %h", qif.fe_queue_v, qif.fe_queue, exp[2]); end
    clk_wait();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", qif.fe_queue_v); end
    clk_wait();
  endtask

  task automatic test_exception();
    bp_fe_queue_s exp;
    exp = mk_exc(VW'(64'h1000), e_itlb_miss);
    qif.fe_queue_ready = 1'b1;
    fetch_v_i = 1'b1;
    fetch_exception_v_i = 1'b1;
    fetch_exception_code_i = e_itlb_miss;
    fetch_pc_i = VW'(64'h1000);
    fetch_instr_i = 32'hdead_beef;
    fetch_branch_metadata_i = MW'(32'hffff_ffff);
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL exc_accept_ready: got %b want 1", fetch_ready_o); end
    clk_wait();
    idle();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b1 || qif.fe_queue !== exp) begin errors++; $display("FAIL exc_msg: got v=%b %h want v=1 %h", qif.fe_queue_v, qif.fe_queue, exp); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL exc_stall_ready: got %b want 0", fetch_ready_o); end
    clk_wait();
    drive_fetch(VW'(64'h1004), 32'h13, MW'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (fetch_ready_o !== 1'b0 || qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL exc_stall[%0d]: got ready=%b v=%b want 0 0", i, fetch_ready_o, qif.fe_queue_v); end
      clk_wait();
    end
    idle();
    flush_i = 1'b1;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL exc_flush_cycle_ready: got %b want 0", fetch_ready_o); end
    clk_wait();
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL exc_after_flush_ready: got %b want 1", fetch_ready_o); end
    clk_wait();
  endtask

  task automatic test_flush_full();
    bp_fe_queue_s exp;
    exp = mk_fetch(VW'(64'h2000), 32'h0000_0093, MW'(32'h55));
    qif.fe_queue_ready = 1'b0;
    drive_fetch(VW'(64'h3000), 32'h1, MW'(1));
    clk_wait();
    drive_fetch(VW'(64'h3004), 32'h2, MW'(2));
    clk_wait();
    idle();
    flush_i = 1'b1;
    qif.fe_queue_ready = 1'b1;
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0 || fetch_ready_o !== 1'b0) begin errors++; $display("FAIL flush_cycle: got v=%b ready=%b want 0 0", qif.fe_queue_v, fetch_ready_o); end
    clk_wait();
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL flush_after: got v=%b ready=%b want 0 1", qif.fe_queue_v, fetch_ready_o); end
    drive_fetch(VW'(64'h2000), 32'h0000_0093, MW'(32'h55));
    clk_wait();
    idle();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b1 || qif.fe_queue !== exp) begin errors++; $display("FAIL flush_first_msg: got v=%b %h want v=1 %h", qif.fe_queue_v, qif.fe_queue, exp); end
    clk_wait();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", qif.fe_queue_v); end
    clk_wait();
  endtask

  task automatic test_wrap();
    bp_fe_queue_s exp [10];
    logic [31:0]  instr;
    logic [MW-1:0] md;
    qif.fe_queue_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) begin
        instr = $urandom();
        md    = $urandom();
        exp[i] = mk_fetch(VW'(64'h4000 + 64'(4 * i)), instr, md);
        drive_fetch(VW'(64'h4000 + 64'(4 * i)), instr, md);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 10) begin
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_ready[%0d]: got %b want 1", i, fetch_ready_o); end
      end
      if (i > 0) begin
        checks++; if (qif.fe_queue_v !== 1'b1 || qif.fe_queue !== exp[i-1]) begin errors++; $display("FAIL wrap_msg[%0d]: got v=%b %h want v=1 %h", i - 1, qif.fe_queue_v, qif.fe_queue, exp[i-1]); end
      end
      clk_wait();
    end
  endtask

  task automatic test_async_reset();
    qif.fe_queue_ready = 1'b0;
    drive_fetch(VW'(64'h5000), 32'h7, MW'(7));
    clk_wait();
    idle();
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b1) begin errors++; $display("FAIL areset_holding: got %b want 1", qif.fe_queue_v); end
    #2;
    reset_i = 1'b1;
    #1;
    checks++; if (qif.fe_queue_v !== 1'b0 || fetch_ready_o !== 1'b0) begin errors++; $display("FAIL areset_immediate: got v=%b ready=%b want 0 0", qif.fe_queue_v, fetch_ready_o); end
    clk_wait();
    reset_i = 1'b0;
    qif.fe_queue_ready = 1'b1;
    @(negedge clk);
    checks++; if (qif.fe_queue_v !== 1'b0 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL areset_release: got v=%b ready=%b want 0 1", qif.fe_queue_v, fetch_ready_o); end
    clk_wait();
  endtask

  task automatic test_random();
    bp_fe_queue_s model_q [$];
    bp_fe_queue_s m;
    bit stalled = 1'b0;
    bit exp_ready, exp_v, acc, deq;
    for (int c = 0; c < 400; c++) begin
      fetch_v_i               = ($urandom_range(0, 9) < 7);
      fetch_pc_i              = VW'({$urandom(), $urandom()});
      fetch_instr_i           = $urandom();
      fetch_branch_metadata_i = MW'($urandom());
      fetch_exception_v_i     = ($urandom_range(0, 9) == 0);
      fetch_exception_code_i  = bp_fe_exception_code_e'($urandom_range(0, 3));
      flush_i                 = stalled ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      qif.fe_queue_ready      = ($urandom_range(0, 9) < 6);
      exp_ready = !stalled && (model_q.size() < ELS) && !flush_i;
      exp_v     = (model_q.size() != 0) && !flush_i;
      @(negedge clk);
      checks++; if (fetch_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, fetch_ready_o, exp_ready); end
      checks++; if (qif.fe_queue_v !== exp_v) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, qif.fe_queue_v, exp_v); end
      if (exp_v) begin
        checks++; if (qif.fe_queue !== model_q[0]) begin errors++; $display("FAIL rnd_msg[%0d]: got %h want %h", c, qif.fe_queue, model_q[0]); end
      end
      acc = fetch_v_i && exp_ready;
      deq = exp_v && qif.fe_queue_ready;
      m = fetch_exception_v_i ? mk_exc(fetch_pc_i, fetch_exception_code_i)
                              : mk_fetch(fetch_pc_i, fetch_instr_i, fetch_branch_metadata_i);
      @(posedge clk);
      if (flush_i) begin
        model_q.delete();
        stalled = 1'b0;
      end else begin
        if (deq) void'(model_q.pop_front());
        if (acc) begin
          model_q.push_back(m);
          if (fetch_exception_v_i) stalled = 1'b1;
        end
      end
      #1;
    end
    idle();
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_exception();
    test_flush_full();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
